// File: rtl/core_ctrl.sv
// core_ctrl: instruction sequencer for the systolic-array core.
// For each kernel position (kij) it runs five phases in order:
//   1. stage weights into L0
//   2. load the weights into the PE array
//   3. stage activations into L0
//   4. execute
//   5. drain the OFIFO into PSUM memory, accumulating when kij > 0
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous reset, active low
//   start        one-cycle pulse that begins a run; ignored while busy
//   kij_count    number of kernel positions, sampled on start
//   w_base       XMEM weight base address, sampled on start
//   x_base       XMEM activation base address, sampled on start
//   p_base       PMEM psum base address, sampled on start
//   ofifo_valid  OFIFO holds a row
//   inst         registered 34-bit instruction word
//   busy         high while a run is in progress (including the done cycle)
//   done         one-cycle completion pulse
//
// Optional build macro CORE_CTRL_READBACK_EN: when defined, a READBACK
// phase after the final drain reads every psum back from PMEM.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start, inst = idle word
// W_L0      | XMEM weight reads, L0 writes one cycle behind (col+1 cycles)
// W_LOAD    | load into PE array, L0 read for first col cycles
// X_L0      | XMEM activation reads, L0 writes one cycle behind
// X_EXEC    | execute with L0 read (len_nij cycles)
// DRAIN     | OFIFO read, then PMEM write the following cycle
// READBACK  | PMEM reads of final psums (optional build only)
// DONE      | one-cycle done pulse
module core_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int len_nij = 36,
  parameter int kij_w   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [kij_w-1:0] kij_count,
  input  logic [10:0]      w_base,
  input  logic [10:0]      x_base,
  input  logic [10:0]      p_base,
  input  logic             ofifo_valid,
  output logic [33:0]      inst,
  output logic             busy,
  output logic             done
);

  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;
  localparam int C_MAX = ((len_nij + 1) > (row + col)) ? (len_nij + 1) : (row + col);
  localparam int CW    = $clog2(C_MAX + 1);
  localparam int NW    = $clog2(len_nij + 1);

  localparam logic [CW-1:0] C_COL       = CW'(col);
  localparam logic [CW-1:0] C_LOAD_LAST = CW'(row + col - 1);
  localparam logic [CW-1:0] C_LEN       = CW'(len_nij);
  localparam logic [CW-1:0] C_LEN_LAST  = CW'(len_nij - 1);
  localparam logic [NW-1:0] N_LEN       = NW'(len_nij);

  typedef enum logic [2:0] {
    S_IDLE, S_W_L0, S_W_LOAD, S_X_L0, S_X_EXEC, S_DRAIN, S_DONE, S_READBACK
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    c_q, c_d;
  logic [kij_w-1:0] k_q, k_d, kij_q, kij_d;
  logic [10:0]      w_base_q, w_base_d, x_base_q, x_base_d, p_base_q, p_base_d;
  logic [NW-1:0]    r_q, r_d, n_q, n_d;
  logic [33:0]      inst_q, inst_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic             acc_en, cen_p, wen_p, cen_x, ofifo_rd, l0_rd, l0_wr, exe, load;
  logic [10:0]      a_p, a_x;
  logic             rd_now, wr_now, last_kij;
  logic [kij_w:0]   k_next_ext;

  // The instruction word is registered, so its fields are computed from the
  // next state/counter values. ofifo_valid is therefore sampled on the edge
  // that launches the matching ofifo_rd.
  always_comb begin
    state_d  = state_q;
    c_d      = c_q + CW'(1);
    k_d      = k_q;
    kij_d    = kij_q;
    w_base_d = w_base_q;
    x_base_d = x_base_q;
    p_base_d = p_base_q;
    r_d      = r_q;
    n_d      = n_q;

    rd_now     = (state_q == S_DRAIN) && inst_q[6];
    wr_now     = (state_q == S_DRAIN) && !inst_q[31];
    k_next_ext = {1'b0, k_q} + {{kij_w{1'b0}}, 1'b1};
    last_kij   = k_next_ext >= {1'b0, kij_q};

    case (state_q)
      S_IDLE: begin
        c_d = '0;
        r_d = '0;
        n_d = '0;
        if (start) begin
          kij_d    = kij_count;
          w_base_d = w_base;
          x_base_d = x_base;
          p_base_d = p_base;
          k_d      = '0;
          state_d  = (kij_count == '0) ? S_DONE : S_W_L0;
        end
      end
      S_W_L0:   if (c_q == C_COL)       begin state_d = S_W_LOAD; c_d = '0; end
      S_W_LOAD: if (c_q == C_LOAD_LAST) begin state_d = S_X_L0;   c_d = '0; end
      S_X_L0:   if (c_q == C_LEN)       begin state_d = S_X_EXEC; c_d = '0; end
      S_X_EXEC: if (c_q == C_LEN_LAST) begin
        state_d = S_DRAIN;
        c_d     = '0;
        r_d     = '0;
        n_d     = '0;
      end
      S_DRAIN: begin
        c_d = c_q;
        // Leave only in the cycle that carries the final PMEM write.
        if (wr_now && (n_q == N_LEN)) begin
          c_d = '0;
          if (last_kij) begin
`ifdef CORE_CTRL_READBACK_EN
            state_d = S_READBACK;
`else
            state_d = S_DONE;
`endif
          end else begin
            k_d     = k_q + kij_w'(1);
            state_d = S_W_L0;
          end
        end
      end
`ifdef CORE_CTRL_READBACK_EN
      S_READBACK: if (c_q == C_LEN) begin state_d = S_DONE; c_d = '0; end
`endif
      S_DONE: begin
        state_d = S_IDLE;
        c_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase

    acc_en   = 1'b0;
    cen_p    = 1'b1;
    wen_p    = 1'b1;
    a_p      = '0;
    cen_x    = 1'b1;
    a_x      = '0;
    ofifo_rd = 1'b0;
    l0_rd    = 1'b0;
    l0_wr    = 1'b0;
    exe      = 1'b0;
    load     = 1'b0;

    case (state_d)
      S_W_L0: begin
        if (c_d < C_COL) begin
          cen_x = 1'b0;
          a_x   = w_base_d + 11'(k_d) * 11'(col) + 11'(c_d);
        end
        l0_wr = (c_d != '0);
      end
      S_W_LOAD: begin
        load  = 1'b1;
        l0_rd = (c_d < C_COL);
      end
      S_X_L0: begin
        if (c_d < C_LEN) begin
          cen_x = 1'b0;
          a_x   = x_base_d + 11'(c_d);
        end
        l0_wr = (c_d != '0);
      end
      S_X_EXEC: begin
        exe   = 1'b1;
        l0_rd = 1'b1;
      end
      S_DRAIN: begin
        if (ofifo_valid && (r_d < N_LEN)) begin
          ofifo_rd = 1'b1;
          r_d      = r_d + NW'(1);
        end
      end
`ifdef CORE_CTRL_READBACK_EN
      S_READBACK: begin
        if (c_d < C_LEN) begin
          cen_p = 1'b0;
          a_p   = p_base_d + 11'(c_d);
        end
      end
`endif
      default: ;
    endcase

    // The write for a read always lands in the next cycle, whatever
    // ofifo_valid does meanwhile.
    if (rd_now) begin
      cen_p  = 1'b0;
      wen_p  = 1'b0;
      a_p    = p_base_q + 11'(n_q);
      acc_en = (k_q != '0);
      n_d    = n_q + NW'(1);
    end

    inst_d = {acc_en, cen_p, wen_p, a_p, cen_x, 1'b1, a_x,
              ofifo_rd, 2'b00, l0_rd, l0_wr, exe, load};
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      c_q      <= '0;
      k_q      <= '0;
      kij_q    <= '0;
      w_base_q <= '0;
      x_base_q <= '0;
      p_base_q <= '0;
      r_q      <= '0;
      n_q      <= '0;
      inst_q   <= IDLE_INST;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      k_q      <= k_d;
      kij_q    <= kij_d;
      w_base_q <= w_base_d;
      x_base_q <= x_base_d;
      p_base_q <= p_base_d;
      r_q      <= r_d;
      n_q      <= n_d;
      inst_q   <= inst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Scoreboard bench for core_ctrl. Stimulus tasks push the expected XMEM
// addresses, PMEM writes (address and acc_en), readback addresses and run
// latency into queues. A monitor on the falling edge pops and compares
// whenever the DUT presents the corresponding activity on inst or done.
module tb_core_ctrl;
  localparam int ROW = 8, COL = 8, LEN = 36, KW = 4;
  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;
  localparam int KIJ_LEN = (COL + 1) + (ROW + COL) + (LEN + 1) + LEN + (LEN + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] kij_count = '0;
  logic [10:0]   w_base = '0, x_base = '0, p_base = '0;
  logic          ofifo_valid = 1'b0;
  logic [33:0]   inst;
  logic          busy, done;

  core_ctrl #(.row(ROW), .col(COL), .len_nij(LEN), .kij_w(KW)) dut (
    .clk(clk), .reset(reset), .start(start), .kij_count(kij_count),
    .w_base(w_base), .x_base(x_base), .p_base(p_base),
    .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: activity with no expected entry", name);
  endtask

  int exp_xa[$];
  int exp_pw[$];
  bit exp_acc[$];
  int exp_rb[$];
  int exp_lat[$];

  int cyc = 0, rise_cyc = 0, done_cnt = 0;
  int xrd_cnt, wr_cnt, rd_cnt, rb_cnt, load_cnt, exec_cnt, l0rd_cnt, l0wr_cnt, bad_bits;
  bit prev_valid = 1'b0, busy_prev = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_valid = 1'b0;
      busy_prev  = 1'b0;
    end else begin
      cyc++;
      if (inst[5:4] != 2'b00 || inst[18] !== 1'b1) bad_bits++;
      if (inst[33] && inst[31]) bad_bits++;
      if (!inst[19]) begin
        xrd_cnt++;
        if (exp_xa.size() == 0) flag("xmem_read");
        else check("a_xmem", 64'(inst[17:7]), 64'(exp_xa.pop_front()));
      end
      if (!inst[32] && !inst[31]) begin
        wr_cnt++;
        if (exp_pw.size() == 0) flag("pmem_write");
        else begin
          check("a_pmem_write", 64'(inst[30:20]), 64'(exp_pw.pop_front()));
          check("acc_en", 64'(inst[33]), 64'(exp_acc.pop_front()));
        end
      end
      if (!inst[32] && inst[31]) begin
        rb_cnt++;
        if (exp_rb.size() == 0) flag("pmem_read");
        else check("a_pmem_read", 64'(inst[30:20]), 64'(exp_rb.pop_front()));
      end
      if (inst[6]) begin
        rd_cnt++;
        check("ofifo_rd_needs_valid", 64'(prev_valid), 64'd1);
      end
      if (inst[0]) load_cnt++;
      if (inst[1]) exec_cnt++;
      if (inst[2]) l0wr_cnt++;
      if (inst[3]) l0rd_cnt++;
      if (busy && !busy_prev) rise_cyc = cyc;
      if (done) begin
        done_cnt++;
        if (exp_lat.size() == 0) flag("done");
        else check("done_latency", 64'(cyc - rise_cyc), 64'(exp_lat.pop_front()));
      end
      prev_valid = ofifo_valid;
      busy_prev  = busy;
    end
  end

  function automatic bit vf(input int mode, input int idx);
    if (mode == 1) begin
      if (idx >= 97 && idx <= 116) return 1'b0;
      if (idx > 116) return ((idx - 117) % 2) == 0;
    end
    return 1'b1;
  endfunction

  task automatic push_exp(input int kij, input int wb, input int xb, input int pb, input int extra);
    for (int k = 0; k < kij; k++) begin
      for (int c = 0; c < COL; c++) exp_xa.push_back((wb + k * COL + c) & 2047);
      for (int c = 0; c < LEN; c++) exp_xa.push_back((xb + c) & 2047);
      for (int n = 0; n < LEN; n++) begin
        exp_pw.push_back((pb + n) & 2047);
        exp_acc.push_back(k != 0);
      end
    end
`ifdef CORE_CTRL_READBACK_EN
    if (kij > 0) begin
      for (int c = 0; c < LEN; c++) exp_rb.push_back((pb + c) & 2047);
      extra += LEN + 1;
    end
`endif
    exp_lat.push_back(kij * KIJ_LEN + extra);
  endtask

  task automatic clear_counts();
    xrd_cnt = 0; wr_cnt = 0; rd_cnt = 0; rb_cnt = 0; load_cnt = 0;
    exec_cnt = 0; l0rd_cnt = 0; l0wr_cnt = 0; bad_bits = 0;
  endtask

  task automatic run(input string tag, input int kij, input int wb, input int xb, input int pb,
                     input int mode, input int extra, input int poke, input int abort_at,
                     input int budget);
    int idx, d0;
    push_exp(kij, wb, xb, pb, extra);
    clear_counts();
    d0 = done_cnt;
    kij_count = KW'(kij);
    w_base = 11'(wb); x_base = 11'(xb); p_base = 11'(pb);
    ofifo_valid = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    ofifo_valid = vf(mode, idx);
    while (done_cnt == d0 && idx < budget) begin
      if (idx == abort_at) begin
        reset = 1'b0;
        #1;
        check({tag, "_abort_inst"}, 64'(inst), 64'(IDLE_INST));
        check({tag, "_abort_busy"}, 64'(busy), 64'd0);
        check({tag, "_abort_done"}, 64'(done), 64'd0);
        repeat (3) @(posedge clk);
        check({tag, "_abort_hold"}, 64'(inst), 64'(IDLE_INST));
        exp_xa.delete(); exp_pw.delete(); exp_acc.delete();
        exp_rb.delete(); exp_lat.delete();
        #1 reset = 1'b1;
        return;
      end
      @(posedge clk); #1;
      idx++;
      start = (idx == poke);
      if (start) kij_count = kij_count + KW'(1);
      ofifo_valid = vf(mode, idx);
    end
    start = 1'b0;
    if (done_cnt == d0) begin
      n_checks++; n_errors++;
      $display("FAIL %s_timeout: no done within %0d cycles", tag, budget);
    end
    check({tag, "_xmem_reads"}, 64'(xrd_cnt), 64'(kij * (COL + LEN)));
    check({tag, "_pmem_writes"}, 64'(wr_cnt), 64'(kij * LEN));
    check({tag, "_ofifo_reads"}, 64'(rd_cnt), 64'(kij * LEN));
    check({tag, "_load"}, 64'(load_cnt), 64'(kij * (ROW + COL)));
    check({tag, "_execute"}, 64'(exec_cnt), 64'(kij * LEN));
    check({tag, "_l0_wr"}, 64'(l0wr_cnt), 64'(kij * (COL + LEN)));
    check({tag, "_l0_rd"}, 64'(l0rd_cnt), 64'(kij * (COL + LEN)));
    check({tag, "_fixed_bits"}, 64'(bad_bits), 64'd0);
`ifdef CORE_CTRL_READBACK_EN
    check({tag, "_pmem_reads"}, 64'(rb_cnt), 64'(kij > 0 ? LEN : 0));
`else
    check({tag, "_pmem_reads"}, 64'(rb_cnt), 64'd0);
`endif
    check({tag, "_queues_empty"},
          64'(exp_xa.size() + exp_pw.size() + exp_rb.size() + exp_lat.size()), 64'd0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_inst", 64'(inst), 64'(IDLE_INST));
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_hold", {28'd0, inst, busy, done}, {28'd0, IDLE_INST, 2'b00});
    end
    @(posedge clk); #1;

    // single kij; start pulsed in the done cycle must be ignored
    run("single", 1, 0, 64, 0, 0, 0, KIJ_LEN, -1, 1000);
    repeat (5) begin
      @(negedge clk);
      check("start_at_done_ignored", 64'(busy), 64'd0);
    end
    @(posedge clk); #1;

    // nine kij, weight addresses wrap; start mid-run ignored
    run("nine", 9, 2040, 64, 0, 0, 0, 500, -1, 2000);
    @(posedge clk); #1;

    // drain stall of 20 cycles then toggling valid
    run("stall", 1, 16, 200, 500, 1, 20 + (LEN - 1), -1, -1, 1000);
    @(posedge clk); #1;

    // no kernel positions
    run("kij0", 0, 0, 0, 0, 0, 0, -1, -1, 20);
    @(posedge clk); #1;

    // reset during X_EXEC, then a clean run with PMEM address wrap
    run("abort", 2, 0, 64, 0, 0, 0, -1, 70, 1000);
    @(posedge clk); #1;
    run("after_abort", 1, 8, 300, 2030, 0, 0, -1, -1, 1000);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
